// File: rtl/rr_arb_pkg.sv
// Shared types and default sizing for the round-robin select arbiter.
package rr_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BUSY  = 2'd2
    } arb_state_t;

    localparam int DEF_N_REQ    = 4;
    localparam int DEF_MAX_HOLD = 16;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority pick: requester at ptr wins first, then ptr+1, ... wrapping.
module rr_pick
    import rr_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int SEL_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] idx,
    output logic             any
);

    logic [N_REQ-1:0] rot;
    logic [SEL_W-1:0] off;

    // Rotate right by ptr so the highest-priority requester lands in bit 0.
    // Index arithmetic wraps naturally because N_REQ is a power of two.
    always_comb begin
        rot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rot[i] = req[SEL_W'(i) + ptr];
        end
    end

    // Lowest set bit of the rotated vector; scanning downward leaves the lowest.
    always_comb begin
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = SEL_W'(i);
        end
    end

    assign idx = off + ptr;
    assign any = |req;

endmodule

// File: rtl/rr_sel_arbiter.sv
// Round-robin arbiter presenting the winner index with a valid/ready handshake,
// holding the grant until done or a hold timeout, then advancing priority.
module rr_sel_arbiter
    import rr_arb_pkg::*;
#(
    parameter int N_REQ    = DEF_N_REQ,
    parameter int SEL_W    = $clog2(N_REQ),
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [N_REQ-1:0] req_in,
    input  logic             ready_in,
    input  logic             done_in,
    output logic [SEL_W-1:0] sel_out,
    output logic             sel_valid_out,
    output logic             busy_out,
    output logic             timeout_out
);

    localparam int               CNT_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

    arb_state_t       state, state_n;
    logic [SEL_W-1:0] ptr, ptr_n, sel_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             timeout_n;
    logic [SEL_W-1:0] pick_idx;
    logic             pick_any;

    rr_pick #(
        .N_REQ (N_REQ),
        .SEL_W (SEL_W)
    ) u_pick (
        .req (req_in),
        .ptr (ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Next-state, pointer, counter and pulse decisions.
    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        sel_n     = sel_out;
        cnt_n     = cnt;
        timeout_n = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    sel_n   = pick_idx;
                    state_n = GRANT;
                end
            end
            GRANT: begin
                // A withdrawn request beats a same-cycle ready.
                if (!req_in[sel_out]) begin
                    state_n = IDLE;
                end else if (ready_in) begin
                    state_n = BUSY;
                    cnt_n   = '0;
                end
            end
            BUSY: begin
                if (done_in) begin
                    state_n = IDLE;
                    ptr_n   = sel_out + 1'b1;
                end else if (cnt == CNT_LAST) begin
                    state_n   = IDLE;
                    ptr_n     = sel_out + 1'b1;
                    timeout_n = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_n;
    end

    // Datapath and registered outputs, derived from the next state so they
    // line up with the state they describe.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ptr           <= '0;
            sel_out       <= '0;
            cnt           <= '0;
            sel_valid_out <= 1'b0;
            busy_out      <= 1'b0;
            timeout_out   <= 1'b0;
        end else begin
            ptr           <= ptr_n;
            sel_out       <= sel_n;
            cnt           <= cnt_n;
            sel_valid_out <= (state_n == GRANT);
            busy_out      <= (state_n == BUSY);
            timeout_out   <= timeout_n;
        end
    end

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Directed bench for rr_sel_arbiter with a grant-order scoreboard.
module tb_rr_sel_arbiter;

    localparam int N_REQ    = 4;
    localparam int SEL_W    = 2;
    localparam int MAX_HOLD = 4;

    logic             clk_in = 1'b0;
    logic             rst_in;
    logic [N_REQ-1:0] req_in;
    logic             ready_in;
    logic             done_in;
    logic [SEL_W-1:0] sel_out;
    logic             sel_valid_out;
    logic             busy_out;
    logic             timeout_out;

    int n_tests = 0;
    int n_fail  = 0;

    logic [SEL_W-1:0] exp_q[$];
    logic [SEL_W-1:0] mptr;

    rr_sel_arbiter #(
        .N_REQ    (N_REQ),
        .SEL_W    (SEL_W),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .req_in        (req_in),
        .ready_in      (ready_in),
        .done_in       (done_in),
        .sel_out       (sel_out),
        .sel_valid_out (sel_valid_out),
        .busy_out      (busy_out),
        .timeout_out   (timeout_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Valid/busy/timeout triple as one value for compact checks.
    function automatic logic [31:0] vbt();
        return {29'd0, sel_valid_out, busy_out, timeout_out};
    endfunction

    // Reference winner: first requester at or after p, wrapping.
    function automatic logic [SEL_W-1:0] model_pick(input logic [N_REQ-1:0] r,
                                                    input logic [SEL_W-1:0] p);
        logic [SEL_W-1:0] j;
        for (int k = 0; k < N_REQ; k++) begin
            j = p + SEL_W'(k);
            if (r[j]) return j;
        end
        return '0;
    endfunction

    task automatic expect_grant();
        exp_q.push_back(model_pick(req_in, mptr));
    endtask

    task automatic pop_chk(input string tag);
        logic [SEL_W-1:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, "_empty_q"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk(tag, 32'(sel_out), 32'(e));
        end
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        mptr   = '0;
    endtask

    initial begin
        rst_in   = 1'b1;
        req_in   = '0;
        ready_in = 1'b0;
        done_in  = 1'b0;
        mptr     = '0;
        tick();
        tick();
        rst_in = 1'b0;

        // Reset state and quiet idle.
        chk("rst_outs", {vbt(), 30'(sel_out)}, 32'd0);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("idle_outs", {vbt(), 30'(sel_out)}, 32'd0);
            chk("idle_ptr", 32'(dut.ptr), 32'd0);
        end

        // Round-robin rotation with done after 2 BUSY cycles.
        req_in   = 4'b1111;
        ready_in = 1'b1;
        for (int g = 0; g < 5; g++) begin
            expect_grant();
            tick();
            chk("rr_valid", vbt(), 32'b100);
            pop_chk("rr_sel");
            tick();
            chk("rr_busy1", vbt(), 32'b010);
            tick();
            chk("rr_busy2", vbt(), 32'b010);
            done_in = 1'b1;
            tick();
            done_in = 1'b0;
            chk("rr_release", vbt(), 32'b000);
            mptr = sel_out + 1'b1;
            chk("rr_ptr", 32'(dut.ptr), 32'(mptr));
        end
        chk("rr_order_last", 32'(sel_out), 32'd0);

        // Withdraw during GRANT.
        do_reset();
        req_in   = 4'b0100;
        ready_in = 1'b0;
        expect_grant();
        tick();
        chk("wd_valid", vbt(), 32'b100);
        pop_chk("wd_sel");
        tick();
        chk("wd_hold", vbt(), 32'b100);
        req_in = 4'b0000;
        tick();
        chk("wd_drop", vbt(), 32'b000);
        chk("wd_ptr", 32'(dut.ptr), 32'd0);
        tick();
        chk("wd_nobusy", vbt(), 32'b000);

        // Hold timeout with a sole requester.
        req_in   = 4'b0001;
        ready_in = 1'b1;
        expect_grant();
        tick();
        chk("to_valid", vbt(), 32'b100);
        pop_chk("to_sel");
        for (int b = 0; b < MAX_HOLD; b++) begin
            tick();
            chk("to_busy", vbt(), 32'b010);
        end
        tick();
        chk("to_pulse", vbt(), 32'b001);
        mptr = 2'd1;
        chk("to_ptr", 32'(dut.ptr), 32'(mptr));
        expect_grant();
        tick();
        chk("to_regrant", vbt(), 32'b100);
        pop_chk("to_regrant_sel");

        // done coinciding with the last hold cycle suppresses the pulse.
        for (int b = 0; b < MAX_HOLD; b++) begin
            tick();
            chk("dt_busy", vbt(), 32'b010);
        end
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
        chk("dt_release", vbt(), 32'b000);
        chk("dt_ptr", 32'(dut.ptr), 32'd1);

        // Reset in the middle of BUSY.
        req_in = 4'b1000;
        mptr   = 2'd1;
        expect_grant();
        tick();
        chk("rb_valid", vbt(), 32'b100);
        pop_chk("rb_sel");
        tick();
        chk("rb_busy", vbt(), 32'b010);
        req_in = 4'b1111;
        do_reset();
        chk("rb_outs", {vbt(), 30'(sel_out)}, 32'd0);
        chk("rb_ptr", 32'(dut.ptr), 32'd0);
        expect_grant();
        tick();
        chk("rb_valid2", vbt(), 32'b100);
        pop_chk("rb_sel2");

        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_sel_arbiter.md
# rr_sel_arbiter

Round-robin arbiter that selects one of `N_REQ` requesters and presents the winner as a binary index with a valid/ready handshake. It sits directly upstream of the 2-bit one-hot priority decoder stage: `sel_out` drives the decoder's select input, and `sel_valid_out`/`busy_out` qualify the decoded one-hot. The arbiter holds a grant until the owner signals done or a hold timeout expires, then advances priority.

## Interface
- `N_REQ`, default 4: number of requesters; power of two, 2 to 16.
- `SEL_W`, default `$clog2(N_REQ)`: width of the index; 2 at the default.
- `MAX_HOLD`, default 16: maximum number of BUSY cycles before a forced release; at least 1.
- `clk_in`, input, 1: the single clock; everything is rising-edge.
- `rst_in`, input, 1: synchronous, active-high reset.
- `req_in`, input, `N_REQ`: request vector, level-sensitive; bit i means requester i wants the resource.
- `ready_in`, input, 1: the consumer accepts the presented index.
- `done_in`, input, 1: the current owner releases the grant.
- `sel_out`, output, `SEL_W`: winning requester index, registered.
- `sel_valid_out`, output, 1: `sel_out` is offered and awaits `ready_in`.
- `busy_out`, output, 1: the grant is accepted and owned.
- `timeout_out`, output, 1: one-cycle pulse when a grant is force-released.

## Operation
- FSM states are IDLE, GRANT and BUSY.
- The arbiter keeps a round-robin pointer `ptr` (`SEL_W` bits). The requester at `ptr` has highest priority; priority descends through `ptr+1`, `ptr+2`, and so on, wrapping modulo `N_REQ`.
- **IDLE**
  - If `req_in` is nonzero: load `sel_out` with the winner and go to GRANT.
  - Otherwise stay in IDLE.
- **GRANT**
  - `sel_valid_out` is 1 and `sel_out` is stable.
  - If `req_in[sel_out]` is 1 and `ready_in` is 1: go to BUSY and clear the hold counter.
  - If `req_in[sel_out]` drops to 0: withdraw and go to IDLE. `ptr` is unchanged. The withdrawal takes priority over `ready_in` in the same cycle.
- **BUSY**
  - `busy_out` is 1, `sel_out` is held, and the hold counter increments each cycle.
  - If `done_in` is 1: go to IDLE and set `ptr <= sel_out + 1` (wraps modulo `N_REQ`).
  - Else if the counter equals `MAX_HOLD-1`: go to IDLE, update `ptr` the same way, and pulse `timeout_out`.
  - If `done_in` and the timeout coincide, `done_in` wins and there is no `timeout_out` pulse.
- `done_in` is ignored in IDLE and GRANT. `ready_in` is ignored outside GRANT.
- Changes to `req_in` during BUSY do not affect ownership.
- Hold counter width is `$clog2(MAX_HOLD)`, with a minimum of 1 bit. It never wraps within one grant.

## Timing
- Reset values: state IDLE, `ptr` 0, `sel_out` 0, `sel_valid_out` 0, `busy_out` 0, `timeout_out` 0, hold counter 0.
- Reset asserted mid-GRANT or mid-BUSY forces the reset values on the next edge. No pulse is generated.
- All outputs are registered, with no combinational input-to-output paths.
- Latency from `req_in` first seen in IDLE to `sel_valid_out` = 1 is 1 cycle.
- From the `ready_in` handshake edge to `busy_out` = 1 is 1 cycle. `sel_valid_out` falls on that same edge.
- From the `done_in` edge, `busy_out` = 0 one cycle later. The earliest next `sel_valid_out` is 2 cycles after `done_in`, because one IDLE arbitration cycle always occurs.
- Maximum ownership is `MAX_HOLD` cycles of `busy_out`.
- `timeout_out` is high for exactly 1 cycle, coincident with the first IDLE cycle.

## Structure
- A shared package `rr_arb_pkg` holds:
  - the state enum `arb_state_t` {IDLE, GRANT, BUSY};
  - the default `N_REQ` and `MAX_HOLD` constants.
- The rotating priority pick is one natural combinational sub-module, `rr_pick`.
  - Inputs: `req` and `ptr`.
  - Outputs: `idx` and `any`.
  - Implementation: rotate right by `ptr`, find the first set bit, add `ptr` modulo `N_REQ`.
- The FSM, pointer, counter and output registers live in `rr_sel_arbiter`.

## Test plan
- After reset with `req_in` = 0000 for 5 cycles: all outputs stay 0 and `ptr` stays 0.
- Hold `req_in` = 1111 with `ready_in` = 1 and pulse `done_in` after 2 BUSY cycles, repeated: grants appear in the order 0, 1, 2, 3, 0. Each `sel_valid_out` appears exactly 2 cycles after the prior `done_in`.
- `req_in` = 0100 only: `sel_out` = 2. Drop bit 2 while in GRANT with `ready_in` = 0: `sel_valid_out` returns to 0 next cycle, `ptr` stays 0, and no BUSY occurs.
- Hold `req_in` = 0001 with `MAX_HOLD` = 4 and no `done_in`: `busy_out` is high for exactly 4 cycles, then `timeout_out` pulses for 1 cycle. The next grant is again index 0, since it is the sole requester, with `ptr` = 1.
- In BUSY, assert `done_in` on the cycle where the counter equals `MAX_HOLD-1`: return to IDLE with `timeout_out` remaining 0.
- Assert `rst_in` for 1 cycle during BUSY with `sel_out` = 3: next cycle all outputs are 0, `ptr` = 0, and with `req_in` = 1111 the next grant is index 0.
